// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  localparam logic [1:0] MWE_READ = 2'b00;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of requester and memory-side signals around the arbiter.
interface mem_arb_if #(
  parameter int N = 64
);

  logic          ireq;
  logic [31:0]   iadr;
  logic          ival;
  logic [31:0]   irdata;
  logic          iabort;

  logic          dreq;
  logic [1:0]    dwe;
  logic [N-1:0]  dadr;
  logic [N-1:0]  dwdata;
  logic          dval;
  logic          dabort;
  logic [N-1:0]  drdata;

  logic          mreq;
  logic [1:0]    mwe;
  logic [N-1:0]  madr;
  logic [N-1:0]  mwdata;
  logic          mval;
  logic [N-1:0]  mrdata;

  // Arbiter side: masters the memory, serves both requesters.
  modport master (
    input  ireq, iadr, dreq, dwe, dadr, dwdata, mval, mrdata,
    output ival, irdata, iabort, dval, dabort, drdata,
    output mreq, mwe, madr, mwdata
  );

  // Environment side: requesters plus memory.
  modport slave (
    output ireq, iadr, dreq, dwe, dadr, dwdata, mval, mrdata,
    input  ival, irdata, iabort, dval, dabort, drdata,
    input  mreq, mwe, madr, mwdata
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter; expired is high once TIMEOUT idle wait cycles have elapsed.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT));

  // NOTE: defaulting cnt_d first keeps every path assigned, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                  cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data side preferred, instruction side protected
// from starvation; one outstanding memory transaction with timeout abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255,
  parameter int STARVE  = 4
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb_if.master bus
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mreq_q, mreq_d;
  logic [1:0]    mwe_q, mwe_d;
  logic [N-1:0]  madr_q, madr_d;
  logic [N-1:0]  mwdata_q, mwdata_d;
  logic          ival_q, ival_d, iabort_q, iabort_d;
  logic          dval_q, dval_d, dabort_q, dabort_d;
  logic [31:0]   irdata_q, irdata_d;
  logic [N-1:0]  drdata_q, drdata_d;
  logic          grant, expired, waiting;
  owner_e        owner;

  assign waiting = (state_q != IDLE);
  assign owner   = (state_q == D_WAIT) ? OWN_D : OWN_I;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (waiting && !bus.mval),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    madr_d   = madr_q;
    mwdata_d = mwdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    ival_d   = 1'b0;
    iabort_d = 1'b0;
    dval_d   = 1'b0;
    dabort_d = 1'b0;
    grant    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins unless the instruction side has already been passed over STARVE times.
        if (bus.dreq && (!bus.ireq || starve_q < SW'(STARVE))) begin
          state_d  = D_WAIT;
          grant    = 1'b1;
          mreq_d   = 1'b1;
          mwe_d    = bus.dwe;
          madr_d   = bus.dadr;
          mwdata_d = bus.dwdata;
          starve_d = bus.ireq ? starve_q + 1'b1 : '0;
        end else if (bus.ireq) begin
          state_d  = I_WAIT;
          grant    = 1'b1;
          mreq_d   = 1'b1;
          mwe_d    = MWE_READ;
          madr_d   = N'(bus.iadr);
          mwdata_d = '0;
          starve_d = '0;
        end
      end
      I_WAIT, D_WAIT: begin
        // A response in the timeout cycle still completes normally.
        if (bus.mval) begin
          state_d = IDLE;
          mreq_d  = 1'b0;
          if (owner == OWN_I) begin
            ival_d   = 1'b1;
            irdata_d = bus.mrdata[31:0];
          end else begin
            dval_d   = 1'b1;
            drdata_d = bus.mrdata;
          end
        end else if (expired) begin
          state_d  = IDLE;
          mreq_d   = 1'b0;
          iabort_d = (owner == OWN_I);
          dabort_d = (owner == OWN_D);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= MWE_READ;
      madr_q   <= '0;
      mwdata_q <= '0;
      ival_q   <= 1'b0;
      iabort_q <= 1'b0;
      dval_q   <= 1'b0;
      dabort_q <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      madr_q   <= madr_d;
      mwdata_q <= mwdata_d;
      ival_q   <= ival_d;
      iabort_q <= iabort_d;
      dval_q   <= dval_d;
      dabort_q <= dabort_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign bus.mreq   = mreq_q;
  assign bus.mwe    = mwe_q;
  assign bus.madr   = madr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.ival   = ival_q;
  assign bus.iabort = iabort_q;
  assign bus.irdata = irdata_q;
  assign bus.dval   = dval_q;
  assign bus.dabort = dabort_q;
  assign bus.drdata = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic early;

  always #5 clk = ~clk;

  mem_arb_if #(.N(64)) bus ();

  mem_arbiter #(.N(64), .TIMEOUT(255), .STARVE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    bus.ireq   = 1'b0;
    bus.iadr   = '0;
    bus.dreq   = 1'b0;
    bus.dwe    = 2'b00;
    bus.dadr   = '0;
    bus.dwdata = '0;
    bus.mval   = 1'b0;
    bus.mrdata = '0;
    tick();
    tick();

    // Reset state
    expect_eq("rst_mreq",   bus.mreq, 0);
    expect_eq("rst_mwe",    bus.mwe, 0);
    expect_eq("rst_madr",   bus.madr, 0);
    expect_eq("rst_mwdata", bus.mwdata, 0);
    expect_eq("rst_pulses", {bus.ival, bus.iabort, bus.dval, bus.dabort}, 0);
    expect_eq("rst_rdata",  {bus.irdata, bus.drdata[31:0]}, 0);

    // Single instruction fetch, response after 3 cycles
    reset = 1'b1;
    bus.ireq = 1'b1; bus.iadr = 32'h40;
    tick();
    expect_eq("i_mreq", bus.mreq, 1);
    expect_eq("i_madr", bus.madr, 64'h40);
    expect_eq("i_mwe",  bus.mwe, 0);
    tick();
    tick();
    expect_eq("i_noval_yet", bus.ival, 0);
    bus.mval = 1'b1; bus.mrdata = 64'h1234;
    tick();
    expect_eq("i_ival",   bus.ival, 1);
    expect_eq("i_irdata", bus.irdata, 32'h1234);
    expect_eq("i_mreq_drop", bus.mreq, 0);
    bus.ireq = 1'b0; bus.mval = 1'b0;
    tick();
    expect_eq("i_ival_one", bus.ival, 0);
    expect_eq("i_irdata_hold", bus.irdata, 32'h1234);

    // Simultaneous requests: data first, instruction after dval
    bus.ireq = 1'b1; bus.iadr = 32'h80;
    bus.dreq = 1'b1; bus.dwe = 2'b01; bus.dadr = 64'h100; bus.dwdata = 64'hAA;
    tick();
    expect_eq("sim_d_madr",   bus.madr, 64'h100);
    expect_eq("sim_d_mwe",    bus.mwe, 2'b01);
    expect_eq("sim_d_mwdata", bus.mwdata, 64'hAA);
    bus.dadr = 64'h999; bus.dwdata = 64'h0; bus.dwe = 2'b10;
    tick();
    expect_eq("sim_latched", {bus.madr[31:0], bus.mwdata[31:0], 30'd0, bus.mwe},
              {32'h100, 32'hAA, 32'h1});
    bus.mval = 1'b1; bus.mrdata = 64'h55;
    tick();
    expect_eq("sim_dval",   bus.dval, 1);
    expect_eq("sim_drdata", bus.drdata, 64'h55);
    expect_eq("sim_no_ival", bus.ival, 0);
    bus.dreq = 1'b0; bus.mval = 1'b0;
    tick();
    expect_eq("sim_i_madr", bus.madr, 64'h80);
    expect_eq("sim_i_mwe",  bus.mwe, 0);
    expect_eq("sim_dval_one", bus.dval, 0);
    bus.mval = 1'b1; bus.mrdata = 64'hFFFF_FFFF_0000_BEEF;
    tick();
    expect_eq("sim_ival",   bus.ival, 1);
    expect_eq("sim_irdata", bus.irdata, 32'h0000_BEEF);
    expect_eq("sim_drdata_hold", bus.drdata, 64'h55);
    bus.ireq = 1'b0; bus.mval = 1'b0;
    tick();

    // Starvation limit: four data grants, then instruction
    bus.ireq = 1'b1; bus.iadr = 32'h300;
    bus.dreq = 1'b1; bus.dwe = 2'b00; bus.dadr = 64'h200;
    for (int g = 1; g <= 5; g++) begin
      tick();
      expect_eq($sformatf("starve_grant%0d", g), bus.madr, (g == 5) ? 64'h300 : 64'h200);
      bus.mval = 1'b1; bus.mrdata = 64'h1000 + 64'(g);
      tick();
      bus.mval = 1'b0;
    end
    expect_eq("starve_ival", bus.ival, 1);
    expect_eq("starve_drdata", bus.drdata, 64'h1004);
    bus.ireq = 1'b0; bus.dreq = 1'b0;
    tick();

    // Data write timeout; requester drops dreq right after grant
    bus.dreq = 1'b1; bus.dwe = 2'b01; bus.dadr = 64'h600;
    tick();
    expect_eq("to_mreq_rise", bus.mreq, 1);
    bus.dreq = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (bus.dabort || bus.dval || !bus.mreq) early = 1'b1;
    end
    expect_eq("to_not_early", early, 0);
    tick();
    expect_eq("to_dabort", bus.dabort, 1);
    expect_eq("to_mreq",   bus.mreq, 0);
    expect_eq("to_no_dval", bus.dval, 0);
    tick();
    expect_eq("to_dabort_one", bus.dabort, 0);

    // Reset in the middle of a data transaction
    bus.dreq = 1'b1; bus.dwe = 2'b01; bus.dadr = 64'h500; bus.dwdata = 64'h77;
    tick();
    expect_eq("mr_mreq", bus.mreq, 1);
    bus.dreq = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    expect_eq("mr_outs", {bus.mreq, bus.mwe, bus.madr[31:0], bus.mwdata[31:0]}, 0);
    expect_eq("mr_pulses", {bus.ival, bus.iabort, bus.dval, bus.dabort}, 0);
    expect_eq("mr_rdata", {bus.irdata, bus.drdata[31:0]}, 0);
    // Late mval lands in IDLE together with an instruction request right after reset
    reset = 1'b1; bus.mval = 1'b1; bus.mrdata = 64'hDEAD;
    bus.ireq = 1'b1; bus.iadr = 32'h44;
    tick();
    expect_eq("mr_late_mval", {bus.dval, bus.ival, bus.drdata[31:0]}, 0);
    expect_eq("mr_first_grant", bus.madr, 64'h44);
    expect_eq("mr_grant_mreq", bus.mreq, 1);

    // Response in the timeout cycle completes normally
    bus.mval = 1'b0; bus.ireq = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (bus.iabort || bus.ival || !bus.mreq) early = 1'b1;
    end
    expect_eq("tc_wait", early, 0);
    bus.mval = 1'b1; bus.mrdata = 64'h0000_0000_CAFE_F00D;
    tick();
    expect_eq("tc_ival",   bus.ival, 1);
    expect_eq("tc_iabort", bus.iabort, 0);
    expect_eq("tc_irdata", bus.irdata, 32'hCAFE_F00D);
    expect_eq("tc_mreq",   bus.mreq, 0);
    bus.mval = 1'b0;
    tick();
    expect_eq("tc_after", {bus.ival, bus.iabort, bus.mreq}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
